// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment BCD counter.
// Provides segment patterns (active-high, bit0 = a ... bit6 = g), the BCD-to-segment
// decoder, an elaboration-time integer-to-BCD converter and a ceil-log2 helper.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1100111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  // Scan FSM: one dead-time cycle, then the digit is shown for the rest of the slot.
  typedef enum logic {StDead, StShow} scan_state_e;

  function automatic logic [6:0] seg7_decode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

  // Up to six BCD digits; digit 0 in [3:0].
  function automatic logic [23:0] to_bcd(input int unsigned value);
    logic [23:0]  bcd;
    int unsigned  rem;
    bcd = '0;
    rem = value;
    for (int i = 0; i < 6; i++) begin
      bcd[4*i +: 4] = 4'(rem % 10);
      rem           = rem / 10;
    end
    return bcd;
  endfunction

  // Bits needed to hold 0..value-1 (at least 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    int unsigned span;
    bits = 1;
    span = 2;
    while (span < value) begin
      span = span * 2;
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/seg7_mux_counter_if.sv
// Control/display bundle of seg7_mux_counter.
// i_inc/i_dec/i_clr : count requests (edge detected inside the counter)
// i_mode            : 0 manual, 1 auto count
// i_blank_lz        : blank leading zeros
// o_seg/o_sel       : segment and digit-select pins
// o_count           : packed BCD count, o_wrap: 1-cycle wrap pulse
interface seg7_mux_counter_if #(
  parameter int unsigned N_DIGITS = 2
) ();
  logic                    i_inc;
  logic                    i_dec;
  logic                    i_clr;
  logic                    i_mode;
  logic                    i_blank_lz;
  logic [6:0]              o_seg;
  logic [N_DIGITS-1:0]     o_sel;
  logic [4*N_DIGITS-1:0]   o_count;
  logic                    o_wrap;

  modport master (
    output i_inc, i_dec, i_clr, i_mode, i_blank_lz,
    input  o_seg, o_sel, o_count, o_wrap
  );

  modport slave (
    input  i_inc, i_dec, i_clr, i_mode, i_blank_lz,
    output o_seg, o_sel, o_count, o_wrap
  );
endinterface

// File: rtl/bcd_digit.sv
// One BCD digit (0..9) with ripple carry/borrow.
// i_clk, i_rst     : clock, synchronous active-high reset
// i_inc / i_dec    : carry / borrow in (step this digit)
// i_load, i_load_val : parallel load, overrides stepping
// o_digit          : current digit
// o_carry/o_borrow : carry / borrow out to the next digit
module bcd_digit (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  output logic [3:0] o_digit,
  output logic       o_carry,
  output logic       o_borrow
);
  logic [3:0] r_digit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_digit <= 4'd0;
    end else if (i_load) begin
      r_digit <= i_load_val;
    end else if (i_inc) begin
      r_digit <= (r_digit >= 4'd9) ? 4'd0 : r_digit + 4'd1;
    end else if (i_dec) begin
      r_digit <= (r_digit == 4'd0 || r_digit > 4'd9) ? 4'd9 : r_digit - 4'd1;
    end
  end

  assign o_digit  = r_digit;
  assign o_carry  = i_inc & (r_digit == 4'd9);
  assign o_borrow = i_dec & (r_digit == 4'd0);
endmodule

// File: rtl/seg7_mux_counter.sv
// N-digit up/down BCD counter driving a time-multiplexed 7-segment display.
// i_clk, i_rst : clock, synchronous active-high reset
// io_bus       : requests in (inc/dec/clr/mode/blank_lz), display and count out
module seg7_mux_counter
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 2,
  parameter int unsigned MAX_COUNT      = 99,
  parameter int unsigned CLK_HZ         = 27000000,
  parameter int unsigned REFRESH_HZ     = 90,
  parameter int unsigned AUTO_HZ        = 1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  seg7_mux_counter_if.slave   io_bus
);
  localparam int unsigned SLOT_CYCLES = CLK_HZ / (REFRESH_HZ * N_DIGITS);
  localparam int unsigned AUTO_DIV    = CLK_HZ / AUTO_HZ;
  localparam int unsigned SLOT_W      = clog2(SLOT_CYCLES);
  localparam int unsigned AUTO_W      = clog2(AUTO_DIV);
  localparam int unsigned IDX_W       = clog2(N_DIGITS);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);

  localparam logic [23:0]            MAX_BCD_FULL = to_bcd(MAX_COUNT);
  localparam logic [4*N_DIGITS-1:0]  MAX_BCD      = MAX_BCD_FULL[4*N_DIGITS-1:0];
  localparam logic [6:0]             SEG_DARK     = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [N_DIGITS-1:0]    SEL_OFF      = SEL_ACTIVE_LOW ? '1 : '0;

  // Edge detection and count control
  logic r_inc_prev, r_dec_prev, r_clr_prev;
  logic w_inc_ev, w_dec_ev, w_clr_ev;
  logic [AUTO_W-1:0] r_auto_cnt;
  logic w_tick, w_do_inc, w_do_dec, w_wrap, w_load, r_wrap;

  assign w_inc_ev = io_bus.i_inc & ~r_inc_prev;
  assign w_dec_ev = io_bus.i_dec & ~r_dec_prev;
  assign w_clr_ev = io_bus.i_clr & ~r_clr_prev;
  assign w_tick   = io_bus.i_mode & (r_auto_cnt == AUTO_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inc_prev <= 1'b0;
      r_dec_prev <= 1'b0;
      r_clr_prev <= 1'b0;
      r_auto_cnt <= '0;
    end else begin
      r_inc_prev <= io_bus.i_inc;
      r_dec_prev <= io_bus.i_dec;
      r_clr_prev <= io_bus.i_clr;
      if (!io_bus.i_mode || w_clr_ev || r_auto_cnt == AUTO_LAST) begin
        r_auto_cnt <= '0;
      end else begin
        r_auto_cnt <= r_auto_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_do_inc = 1'b0;
    w_do_dec = 1'b0;
    if (!w_clr_ev) begin
      if (io_bus.i_mode) begin
        w_do_inc = w_tick;
      end else begin
        // Simultaneous inc and dec cancel.
        w_do_inc = w_inc_ev & ~w_dec_ev;
        w_do_dec = w_dec_ev & ~w_inc_ev;
      end
    end
  end

  // BCD digit chain
  logic [4*N_DIGITS-1:0] w_count;
  logic [3:0]            w_digit [N_DIGITS];
  logic [N_DIGITS:0]     w_carry;
  logic [N_DIGITS:0]     w_borrow;
  logic                  w_unused_ripple;

  // Wraps reload the whole count rather than relying on the ripple.
  assign w_wrap = (w_do_inc & (w_count == MAX_BCD)) | (w_do_dec & (w_count == '0));
  assign w_load = w_clr_ev | w_wrap;
  assign w_carry[0]  = w_do_inc;
  assign w_borrow[0] = w_do_dec;
  assign w_unused_ripple = w_carry[N_DIGITS] ^ w_borrow[N_DIGITS];

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_inc      (w_carry[g]),
      .i_dec      (w_borrow[g]),
      .i_load     (w_load),
      .i_load_val (w_do_dec ? MAX_BCD[4*g +: 4] : 4'd0),
      .o_digit    (w_digit[g]),
      .o_carry    (w_carry[g+1]),
      .o_borrow   (w_borrow[g+1])
    );
    assign w_count[4*g +: 4] = w_digit[g];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_wrap <= 1'b0;
    else       r_wrap <= w_wrap;
  end

  // Leading-zero blanking: digit k>0 dark when it and every higher digit is 0.
  logic [N_DIGITS-1:0] w_blank;
  always_comb begin
    logic zero_run;
    w_blank  = '0;
    zero_run = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_run   = zero_run & (w_digit[k] == 4'd0);
      w_blank[k] = io_bus.i_blank_lz & zero_run & (k != 0);
    end
  end

  // Scan / dead-time FSM
  scan_state_e          r_state;
  logic [SLOT_W-1:0]    r_slot_cnt;
  logic [IDX_W-1:0]     r_scan_idx;
  logic [6:0]           r_seg;
  logic [N_DIGITS-1:0]  r_sel;
  logic [6:0]           w_seg_raw;
  logic [N_DIGITS-1:0]  w_sel_hot;

  assign w_seg_raw = w_blank[r_scan_idx] ? SEG_OFF : seg7_decode(w_digit[r_scan_idx]);
  assign w_sel_hot = N_DIGITS'(1) << r_scan_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StDead;
      r_slot_cnt <= '0;
      r_scan_idx <= '0;
      r_seg      <= SEG_DARK;
      r_sel      <= SEL_OFF;
    end else begin
      r_slot_cnt <= (r_slot_cnt == SLOT_LAST) ? '0 : r_slot_cnt + 1'b1;
      case (r_state)
        StDead: begin
          // Sample the count once per slot so a slot never mixes two values.
          r_state <= StShow;
          r_seg   <= SEG_ACTIVE_LOW ? ~w_seg_raw : w_seg_raw;
          r_sel   <= SEL_ACTIVE_LOW ? ~w_sel_hot : w_sel_hot;
        end
        default: begin
          if (r_slot_cnt == SLOT_LAST) begin
            r_state    <= StDead;
            r_sel      <= SEL_OFF;
            r_scan_idx <= (r_scan_idx == IDX_LAST) ? '0 : r_scan_idx + 1'b1;
          end
        end
      endcase
    end
  end

  assign io_bus.o_seg   = r_seg;
  assign io_bus.o_sel   = r_sel;
  assign io_bus.o_count = w_count;
  assign io_bus.o_wrap  = r_wrap;
endmodule
